// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage pipeline control unit: datapath width,
// machine trap cause codes, controller state encoding and small address
// helpers.
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int XLEN = 32;

  // Machine-mode trap causes
  localparam logic [XLEN-1:0] MCAUSE_ECALL_M    = 32'd11;
  localparam logic [XLEN-1:0] MCAUSE_BREAKPOINT = 32'd3;

  // Control sequencer states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,  // normal flow, events accepted from EX
    ST_REDIR = 2'd1,  // redirect pending, waiting for the IFU to accept
    ST_DRAIN = 2'd2,  // fence.i: waiting for MEM/WB to empty
    ST_HALT  = 2'd3   // ebreak reached, frozen until reset
  } ctrl_state_e;

  // Sequential next PC; wraps modulo 2^XLEN
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles every pipeline-facing signal of the control unit.
//   master : the control unit (consumes ID/EX/CSR/status, drives controls)
//   slave  : the pipeline datapath side (drives ID/EX/CSR/status, consumes
//            stall/flush/redirect/CSR strobes/halt/counters)
// Parameter CNT_W sets the width of the performance counters.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  // ID stage hazard info
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  // EX stage results
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd;
  logic            ex_mem_ren;
  logic            ex_branch_taken;
  logic            ex_is_jump;
  logic            ex_is_fence;
  logic            ex_ecall;
  logic            ex_mret;
  logic            ex_ebreak;
  logic [XLEN-1:0] ex_branch_target;
  // CSR and downstream status
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            mem_idle;
  logic            wb_idle;
  logic            redirect_ready;
  // Controls produced by the control unit
  logic            stall_if;
  logic            stall_id;
  logic            bubble_ex;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            icache_flush;
  logic            mepc_wen;
  logic            mcause_wen;
  logic [XLEN-1:0] mepc_wdata;
  logic [XLEN-1:0] mcause_wdata;
  logic            halt;
  logic            drain_err;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_ready, ex_pc, ex_rd, ex_mem_ren,
    input  ex_branch_taken, ex_is_jump, ex_is_fence, ex_ecall, ex_mret, ex_ebreak,
    input  ex_branch_target, csr_mtvec, csr_mepc, mem_idle, wb_idle, redirect_ready,
    output stall_if, stall_id, bubble_ex, flush, redirect_valid, redirect_pc,
    output icache_flush, mepc_wen, mcause_wen, mepc_wdata, mcause_wdata,
    output halt, drain_err, flush_cnt, stall_cnt
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_ready, ex_pc, ex_rd, ex_mem_ren,
    output ex_branch_taken, ex_is_jump, ex_is_fence, ex_ecall, ex_mret, ex_ebreak,
    output ex_branch_target, csr_mtvec, csr_mepc, mem_idle, wb_idle, redirect_ready,
    input  stall_if, stall_id, bubble_ex, flush, redirect_valid, redirect_pc,
    input  icache_flush, mepc_wen, mcause_wen, mepc_wdata, mcause_wdata,
    input  halt, drain_err, flush_cnt, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator: flags when the instruction in ID
// reads a register that the load currently in EX will write.
//   id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i : ID operands
//   ex_valid_i, ex_mem_ren_i, ex_rd_i                             : EX load info
//   hz_o                                                          : hazard flag
// -----------------------------------------------------------------------------
module hazard_detect (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_ren_i,
  input  logic [4:0] ex_rd_i,
  output logic       hz_o
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is never written, so a load targeting it cannot create a dependency
  assign hz_o = id_valid_i && ex_valid_i && ex_mem_ren_i && (ex_rd_i != 5'd0)
                && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central control/sequencing unit of the 5-stage pipeline. Turns EX-stage
// branch/jump/fence/system results and ID hazard info into stall, bubble,
// flush and fetch-redirect controls, trap CSR writes and the halt condition.
// Sequences redirect back-pressure, fence.i drain with I-cache invalidate and
// ebreak halt.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : pipeline_ctrl_if.master carrying all pipeline-facing signals
// Parameters: DRAIN_TIMEOUT (max DRAIN cycles), CNT_W (perf counter width),
//             MCAUSE_ECALL (mcause written on ecall).
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int              DRAIN_TIMEOUT = 1024,
  parameter int              CNT_W         = 32,
  parameter logic [XLEN-1:0] MCAUSE_ECALL  = MCAUSE_ECALL_M
) (
  input logic              clk,
  input logic              rst,
  pipeline_ctrl_if.master  bus
);

  localparam int              TMO_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  ctrl_state_e      state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;          // pending redirect target
  logic [TMO_W-1:0] tmo_q, tmo_d;        // cycles spent in DRAIN
  logic             drain_err_q, drain_err_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             hz;
  logic             ex_fire;
  logic             drain_idle;
  logic             flush_evt;
  logic             redir_evt;
  logic [XLEN-1:0]  redir_tgt;
  logic             stall_if_c, stall_id_c, bubble_ex_c, flush_c;
  logic             redirect_valid_c, icache_flush_c, csr_wen_c, halt_c;
  logic [XLEN-1:0]  redirect_pc_c;

  hazard_detect u_hazard_detect (
    .id_valid_i    (bus.id_valid),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs1_i (bus.id_uses_rs1),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_valid_i    (bus.ex_valid),
    .ex_mem_ren_i  (bus.ex_mem_ren),
    .ex_rd_i       (bus.ex_rd),
    .hz_o          (hz)
  );

  assign ex_fire    = bus.ex_valid && bus.ex_ready;
  assign drain_idle = bus.mem_idle && bus.wb_idle;

  // Next-state and control-output decode
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    tmo_d            = tmo_q;
    drain_err_d      = drain_err_q;
    stall_if_c       = 1'b0;
    stall_id_c       = 1'b0;
    bubble_ex_c      = 1'b0;
    flush_c          = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = pc_q;
    icache_flush_c   = 1'b0;
    csr_wen_c        = 1'b0;
    halt_c           = 1'b0;
    flush_evt        = 1'b0;
    redir_evt        = 1'b0;
    redir_tgt        = pc_q;

    case (state_q)
      ST_RUN: begin
        // Priority chain: ebreak > ecall > mret > fence > jump/taken branch
        if (ex_fire && bus.ex_ebreak) begin
          flush_evt = 1'b1;
          state_d   = ST_HALT;
        end else if (ex_fire && bus.ex_ecall) begin
          redir_evt = 1'b1;
          redir_tgt = bus.csr_mtvec;
          csr_wen_c = 1'b1;
        end else if (ex_fire && bus.ex_mret) begin
          redir_evt = 1'b1;
          redir_tgt = bus.csr_mepc;
        end else if (ex_fire && bus.ex_is_fence) begin
          flush_evt = 1'b1;
          pc_d      = pc_plus4(bus.ex_pc);
          tmo_d     = '0;
          state_d   = ST_DRAIN;
        end else if (ex_fire && (bus.ex_is_jump || bus.ex_branch_taken)) begin
          redir_evt = 1'b1;
          redir_tgt = bus.ex_branch_target;
        end else if (hz) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end else begin
          state_d = ST_RUN;
        end

        // Redirect goes out combinationally; keep the target only if refused
        if (redir_evt) begin
          flush_evt        = 1'b1;
          redirect_valid_c = 1'b1;
          redirect_pc_c    = redir_tgt;
          if (!bus.redirect_ready) begin
            pc_d    = redir_tgt;
            state_d = ST_REDIR;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          redirect_valid_c = 1'b0;
        end
        flush_c = flush_evt;
      end

      ST_REDIR: begin
        flush_c          = 1'b1;
        stall_if_c       = 1'b1;
        redirect_valid_c = 1'b1;
        if (bus.redirect_ready) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_REDIR;
        end
      end

      ST_DRAIN: begin
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        flush_c    = 1'b1;
        tmo_d      = tmo_q + TMO_ONE;
        // Normal completion and timeout share the same exit path
        if (drain_idle || (tmo_q == TMO_LAST)) begin
          if (!drain_idle) begin
            drain_err_d = 1'b1;
          end else begin
            drain_err_d = drain_err_q;
          end
          icache_flush_c   = 1'b1;
          redirect_valid_c = 1'b1;
          if (bus.redirect_ready) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_REDIR;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_HALT: begin
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        flush_c    = 1'b1;
        halt_c     = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating performance counters
  assign flush_cnt_d = (flush_evt && (flush_cnt_q != CNT_MAX)) ? (flush_cnt_q + CNT_ONE) : flush_cnt_q;
  assign stall_cnt_d = (stall_id_c && (stall_cnt_q != CNT_MAX)) ? (stall_cnt_q + CNT_ONE) : stall_cnt_q;

  // State, pending target, drain timer, sticky error and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= 32'd0;
      tmo_q       <= '0;
      drain_err_q <= 1'b0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tmo_q       <= tmo_d;
      drain_err_q <= drain_err_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_if       = stall_if_c;
  assign bus.stall_id       = stall_id_c;
  assign bus.bubble_ex      = bubble_ex_c;
  assign bus.flush          = flush_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;
  assign bus.icache_flush   = icache_flush_c;
  assign bus.mepc_wen       = csr_wen_c;
  assign bus.mcause_wen     = csr_wen_c;
  // Write data is driven only alongside its strobe
  assign bus.mepc_wdata     = csr_wen_c ? bus.ex_pc : 32'd0;
  assign bus.mcause_wdata   = csr_wen_c ? MCAUSE_ECALL : 32'd0;
  assign bus.halt           = halt_c;
  assign bus.drain_err      = drain_err_q;
  assign bus.flush_cnt      = flush_cnt_q;
  assign bus.stall_cnt      = stall_cnt_q;

endmodule
